// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the column configuration frame writer: FSM states, header sync
// pattern and header field positions.
package fabric_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } cfg_state_e;

  localparam logic [7:0] CFG_SYNC = 8'hA5;

  localparam int unsigned IDX_LSB  = 0;
  localparam int unsigned IDX_MSB  = 4;
  localparam int unsigned COL_LSB  = 8;
  localparam int unsigned COL_MSB  = 15;
  localparam int unsigned SYNC_LSB = 24;
  localparam int unsigned SYNC_MSB = 31;

  localparam int unsigned IDX_W = IDX_MSB - IDX_LSB + 1;

endpackage

// File: rtl/column_frame_writer_if.sv
// Valid/ready word stream carrying frame headers and row data into the column writer.
interface column_frame_writer_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [DataWidth-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/frame_row_buffer.sv
// NumRows x FrameBitsPerRow register file holding the frame presented on FrameData.
module frame_row_buffer #(
  parameter int unsigned NumRows         = 7,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned AddrW           = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               we_i,
  input  logic [AddrW-1:0]                   addr_i,
  input  logic [FrameBitsPerRow-1:0]         wdata_i,
  output logic [NumRows*FrameBitsPerRow-1:0] frame_data_o
);

  logic [NumRows*FrameBitsPerRow-1:0] rows_q;

  // Write the addressed row; all other rows hold their value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rows_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NumRows; r++) begin
        if (we_i && (addr_i == AddrW'(r))) begin
          rows_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= wdata_i;
        end
      end
    end
  end

  assign frame_data_o = rows_q;

endmodule

// File: rtl/column_frame_writer.sv
// Column-top configuration frame writer: collects header + NumRows words, then pulses one
// FrameStrobe bit to latch the assembled frame. Frames for other columns are swallowed.
module column_frame_writer
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 7,
  parameter logic [7:0]  ColumnId        = 8'd0
) (
  input  logic                               UserCLK,
  input  logic                               rst,
  column_frame_writer_if.slave               cfg,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               err
);

  localparam int unsigned CntW = (NumRows > 1) ? $clog2(NumRows) : 1;

  cfg_state_e                 state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       match_q, match_d;
  logic                       err_q, err_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic [MaxFramesPerCol-1:0] strobe_hot;
  logic                       ready, xfer, row_we;
  logic [IDX_W-1:0]           hdr_idx;
  logic [7:0]                 hdr_col, hdr_sync;
  logic                       col_hit, idx_ok;

  assign ready    = (state_q == IDLE) || (state_q == LOAD);
  assign xfer     = cfg.cfg_valid && ready;
  assign hdr_idx  = cfg.cfg_data[IDX_MSB:IDX_LSB];
  assign hdr_col  = cfg.cfg_data[COL_MSB:COL_LSB];
  assign hdr_sync = cfg.cfg_data[SYNC_MSB:SYNC_LSB];
  assign col_hit  = (hdr_col == ColumnId);
  assign idx_ok   = (32'(hdr_idx) < MaxFramesPerCol);

  // Decode the latched frame index to a one-hot strobe pattern.
  always_comb begin
    strobe_hot = '0;
    for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
      if (idx_q == IDX_W'(i)) strobe_hot[i] = 1'b1;
    end
  end

  // State, counter, header latches and registered strobe.
  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      match_q  <= match_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
    end
  end

  // Next-state logic; the strobe is armed on the last data word so it appears in STROBE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    match_d  = match_q;
    err_d    = err_q;
    strobe_d = '0;
    row_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer && (hdr_sync == CFG_SYNC)) begin
          idx_d   = hdr_idx;
          match_d = col_hit && idx_ok;
          if (col_hit && !idx_ok) err_d = 1'b1;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          row_we = match_q;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(NumRows - 1)) begin
            if (match_q) begin
              state_d  = STROBE;
              strobe_d = strobe_hot;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  frame_row_buffer #(
    .NumRows         (NumRows),
    .FrameBitsPerRow (FrameBitsPerRow),
    .AddrW           (CntW)
  ) u_rows (
    .clk_i        (UserCLK),
    .rst_ni       (rst),
    .we_i         (row_we),
    .addr_i       (cnt_q),
    .wdata_i      (cfg.cfg_data),
    .frame_data_o (FrameData)
  );

  assign cfg.cfg_ready = ready;
  assign FrameStrobe   = strobe_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_column_frame_writer.sv
// Scoreboard bench: frame stimulus pushes the expected strobe/FrameData; a monitor pops and
// compares whenever FrameStrobe fires, and also checks the STROBE/HOLD handshake timing.
module tb_column_frame_writer;

  localparam int unsigned NR  = 7;
  localparam int unsigned MF  = 20;
  localparam int unsigned FB  = 32;
  localparam logic [7:0]  CID = 8'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  column_frame_writer_if #(.DataWidth(FB)) cfg_if ();

  logic [NR*FB-1:0] frame_data;
  logic [MF-1:0]    frame_strobe;
  logic             busy, err;

  column_frame_writer #(
    .MaxFramesPerCol (MF),
    .FrameBitsPerRow (FB),
    .NumRows         (NR),
    .ColumnId        (CID)
  ) dut (
    .UserCLK     (clk),
    .rst         (rst_n),
    .cfg         (cfg_if),
    .FrameData   (frame_data),
    .FrameStrobe (frame_strobe),
    .busy        (busy),
    .err         (err)
  );

  typedef struct {
    logic [MF-1:0]    strobe;
    logic [NR*FB-1:0] data;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               last_xfer_cyc = -10;
  int               post = 0;
  logic [NR*FB-1:0] model_data = '0;

  task automatic chk(input bit ok, input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one word from a negedge and hold it until accepted; returns on a negedge.
  task automatic send_word(input logic [31:0] w, input int gap);
    int waits;
    if (gap > 0) begin
      cfg_if.cfg_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    cfg_if.cfg_data  = w;
    cfg_if.cfg_valid = 1'b1;
    waits = 0;
    while (!cfg_if.cfg_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!cfg_if.cfg_ready) begin
      chk(1'b0, "ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      last_xfer_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input bit gaps,
                            input int sbit);
    exp_t e;
    if (sbit >= 0) begin
      e.strobe       = '0;
      e.strobe[sbit] = 1'b1;
      for (int r = 0; r < NR; r++) e.data[r*FB +: FB] = base + 32'(r);
      sb_q.push_back(e);
      model_data = e.data;
    end
    send_word(hdr, 0);
    for (int r = 0; r < NR; r++) begin
      send_word(base + 32'(r), gaps ? int'($urandom_range(0, 3)) : 0);
    end
    cfg_if.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;

    // Monitor: compare each strobe against the scoreboard and follow it through HOLD.
    fork
      forever begin
        exp_t m;
        @(negedge clk);
        cyc++;
        if (post == 1) begin
          chk(frame_strobe == '0, "strobe_width", frame_strobe, 0);
          chk(!cfg_if.cfg_ready && busy, "hold_ready_busy", {cfg_if.cfg_ready, busy}, 2'b01);
          post = 2;
        end else begin
          if (post == 2) begin
            chk(cfg_if.cfg_ready && !busy, "idle_after_hold", {cfg_if.cfg_ready, busy}, 2'b10);
            post = 0;
          end
          if (frame_strobe != '0) begin
            if (sb_q.size() == 0) begin
              chk(1'b0, "unexpected_strobe", frame_strobe, 0);
            end else begin
              m = sb_q.pop_front();
              chk(frame_strobe == m.strobe, "strobe_value", frame_strobe, m.strobe);
              chk(frame_data == m.data, "frame_data", frame_data, m.data);
              chk(cyc == last_xfer_cyc + 1, "strobe_latency", cyc, last_xfer_cyc + 1);
              chk(!cfg_if.cfg_ready && busy, "strobe_ready_busy",
                  {cfg_if.cfg_ready, busy}, 2'b01);
              post = 1;
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk(frame_data == '0, "rst_framedata", frame_data, 0);
    chk(frame_strobe == '0, "rst_strobe", frame_strobe, 0);
    chk({busy, err} == 2'b00, "rst_busy_err", {busy, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(cfg_if.cfg_ready == 1'b1, "idle_ready", cfg_if.cfg_ready, 1);

    // 1: matching frame, idx 5
    send_frame(32'hA500_0305, 32'h10, 1'b0, 5);

    // 2: other column, discarded
    send_frame(32'hA500_0705, 32'h20, 1'b0, -1);
    chk(frame_data == model_data, "other_col_data", frame_data, model_data);
    chk(err == 1'b0, "other_col_err", err, 0);

    // 3: bad index sets sticky err, later frame still strobes
    send_frame(32'hA500_0316, 32'h30, 1'b0, -1);
    chk(err == 1'b1, "bad_idx_err", err, 1);
    chk(frame_data == model_data, "bad_idx_data", frame_data, model_data);
    send_frame(32'hA500_0301, 32'h40, 1'b0, 1);
    chk(err == 1'b1, "err_sticky", err, 1);

    // 4: bad sync dropped
    send_word(32'h5A00_0305, 0);
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    chk(busy == 1'b0, "bad_sync_idle", busy, 0);
    send_frame(32'hA500_0305, 32'h50, 1'b0, 5);

    // 5: random gaps, idx 0
    send_frame(32'hA500_0300, 32'h60, 1'b1, 0);

    // 6: reset after 3 data words
    send_word(32'hA500_0304, 0);
    for (int r = 0; r < 3; r++) send_word(32'h70 + 32'(r), 0);
    cfg_if.cfg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk(frame_data == '0, "midrst_framedata", frame_data, 0);
    chk(frame_strobe == '0, "midrst_strobe", frame_strobe, 0);
    chk({busy, err} == 2'b00, "midrst_busy_err", {busy, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk(cfg_if.cfg_ready == 1'b1, "ready_after_rst", cfg_if.cfg_ready, 1);
    send_frame(32'hA500_0307, 32'h80, 1'b0, 7);

    repeat (5) @(negedge clk);
    chk(sb_q.size() == 0, "all_strobes_seen", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
